// File: rtl/abfn_uart_1_sb_osc_supervisor.sv
// abfn_uart_1_sb_osc_supervisor
// Crystal oscillator supervisor running on the fabric RC clock. The crystal
// output is sampled as data; its rising edges are counted over fixed windows
// to qualify the frequency before the clock-source select moves to the crystal.
// Optional build macro: OSC_SUP_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the synchronizer (edge latency 5 cycles instead of 3).
module abfn_uart_1_sb_osc_supervisor #(
    parameter int STARTUP_CYCLES = 1024,
    parameter int WINDOW_CYCLES  = 4096,
    parameter int MIN_EDGES      = 78,
    parameter int MAX_EDGES      = 86,
    parameter int PASS_NEEDED    = 2,
    parameter int RETRY_MAX      = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        XTL_CLK_IN,
    input  logic        ENABLE,
    input  logic        FORCE_RC,
    output logic        CLK_SEL,
    output logic        READY,
    output logic        FAULT,
    output logic [15:0] EDGE_COUNT,
    output logic        MEAS_VALID
);

    localparam int TMAX = (STARTUP_CYCLES > WINDOW_CYCLES) ? STARTUP_CYCLES : WINDOW_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_EVALUATE = 3'd3,
        ST_LOCKED   = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            r_edge;
    logic            w_src;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_inc;
    logic [7:0]      r_pass;
    logic [7:0]      r_fail;
    logic [7:0]      w_pass_nxt;
    logic [7:0]      w_fail_nxt;
    logic [7:0]      w_pass_inc;
    logic [7:0]      w_fail_inc;
    logic            w_latch;
    logic            w_counting;
    logic            w_win_last;
    logic            w_pass;
    logic            r_clk_sel;
    logic            r_ready;
    logic            r_fault;
    logic [15:0]     r_edge_count;
    logic            r_meas_valid;

    // Two-flop synchronizer: crystal output is asynchronous to CLK
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= XTL_CLK_IN;
            r_sync2 <= r_sync1;
        end
    end

`ifdef OSC_SUP_GLITCH_FILTER_EN
    logic r_maj1;
    logic r_maj2;
    logic r_filt;

    // Majority of three consecutive samples rejects single-cycle glitches
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_maj1 <= 1'b0;
            r_maj2 <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_maj1 <= r_sync2;
            r_maj2 <= r_maj1;
            r_filt <= (r_sync2 & r_maj1) | (r_sync2 & r_maj2) | (r_maj1 & r_maj2);
        end
    end

    assign w_src = r_filt;
`else
    assign w_src = r_sync2;
`endif

    // Registered rising-edge detector on the (optionally filtered) crystal sample
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_prev <= w_src;
            r_edge <= w_src & ~r_prev;
        end
    end

    // In LOCKED the timer value WINDOW_CYCLES is the evaluate slot; edges there are not counted
    assign w_win_last = (r_timer == TW'(WINDOW_CYCLES - 1));
    assign w_counting = (r_state == ST_MEASURE) ||
                        ((r_state == ST_LOCKED) && (r_timer != TW'(WINDOW_CYCLES)));
    assign w_cnt_inc  = (w_counting && r_edge && (r_cnt != 16'hFFFF)) ? (r_cnt + 16'd1) : r_cnt;
    assign w_pass     = (r_edge_count >= 16'(MIN_EDGES)) && (r_edge_count <= 16'(MAX_EDGES));
    assign w_pass_inc = r_pass + 8'd1;
    assign w_fail_inc = r_fail + 8'd1;

    // Next-state, timer and pass/fail bookkeeping
    always_comb begin
        w_next      = r_state;
        w_timer_nxt = r_timer + TW'(1);
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_latch     = 1'b0;
        if (!ENABLE) begin
            w_next      = ST_IDLE;
            w_timer_nxt = '0;
            w_pass_nxt  = 8'd0;
            w_fail_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next      = ST_STARTUP;
                    w_timer_nxt = '0;
                    w_pass_nxt  = 8'd0;
                    w_fail_nxt  = 8'd0;
                end
                ST_STARTUP: begin
                    if (r_timer == TW'(STARTUP_CYCLES - 1)) begin
                        w_next      = ST_MEASURE;
                        w_timer_nxt = '0;
                    end else begin
                        w_next = ST_STARTUP;
                    end
                end
                ST_MEASURE: begin
                    if (w_win_last) begin
                        w_next      = ST_EVALUATE;
                        w_timer_nxt = '0;
                        w_latch     = 1'b1;
                    end else begin
                        w_next = ST_MEASURE;
                    end
                end
                ST_EVALUATE: begin
                    w_timer_nxt = '0;
                    if (w_pass) begin
                        w_pass_nxt = w_pass_inc;
                        w_fail_nxt = 8'd0;
                        w_next     = (w_pass_inc >= 8'(PASS_NEEDED)) ? ST_LOCKED : ST_MEASURE;
                    end else begin
                        w_pass_nxt = 8'd0;
                        w_fail_nxt = w_fail_inc;
                        w_next     = (w_fail_inc >= 8'(RETRY_MAX)) ? ST_FAULT : ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (w_win_last) begin
                        w_latch = 1'b1;
                    end else if (r_timer == TW'(WINDOW_CYCLES)) begin
                        w_timer_nxt = '0;
                        if (w_pass) begin
                            w_fail_nxt = 8'd0;
                        end else begin
                            w_next     = ST_MEASURE;
                            w_pass_nxt = 8'd0;
                            w_fail_nxt = 8'd1;
                        end
                    end else begin
                        w_next = ST_LOCKED;
                    end
                end
                ST_FAULT: begin
                    w_timer_nxt = '0;
                end
                default: begin
                    w_next      = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // State, timer, window counter and qualification counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cnt   <= 16'd0;
            r_pass  <= 8'd0;
            r_fail  <= 8'd0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            r_cnt   <= (w_latch || !ENABLE || !w_counting) ? 16'd0 : w_cnt_inc;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    // Outputs registered from the next state so they track the state cycle-for-cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_sel    <= 1'b0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
            r_edge_count <= 16'd0;
            r_meas_valid <= 1'b0;
        end else begin
            r_clk_sel    <= (w_next == ST_LOCKED) && !FORCE_RC;
            r_ready      <= (w_next == ST_LOCKED);
            r_fault      <= (w_next == ST_FAULT);
            r_edge_count <= w_latch ? w_cnt_inc : r_edge_count;
            r_meas_valid <= w_latch;
        end
    end

    assign CLK_SEL    = r_clk_sel;
    assign READY      = r_ready;
    assign FAULT      = r_fault;
    assign EDGE_COUNT = r_edge_count;
    assign MEAS_VALID = r_meas_valid;

endmodule

// File: tb/tb_abfn_uart_1_sb_osc_supervisor.sv
// Directed bench for abfn_uart_1_sb_osc_supervisor with S=16, W=100, MIN=9, MAX=11.
// cyc counts CLK rising edges; all checks and input changes occur 1 time unit after an edge.
module tb_abfn_uart_1_sb_osc_supervisor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        xtl = 1'b0;
    logic        en = 1'b0;
    logic        force_rc = 1'b0;
    logic        clk_sel;
    logic        ready;
    logic        fault;
    logic [15:0] edge_count;
    logic        meas_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int k = 0;
    int per = 10;
    int last_per = 10;
    int ph = 0;
    bit glitch = 1'b0;
    int exp_glitch;

    abfn_uart_1_sb_osc_supervisor #(
        .STARTUP_CYCLES(16),
        .WINDOW_CYCLES (100),
        .MIN_EDGES     (9),
        .MAX_EDGES     (11),
        .PASS_NEEDED   (2),
        .RETRY_MAX     (3)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .XTL_CLK_IN(xtl),
        .ENABLE    (en),
        .FORCE_RC  (force_rc),
        .CLK_SEL   (clk_sel),
        .READY     (ready),
        .FAULT     (fault),
        .EDGE_COUNT(edge_count),
        .MEAS_VALID(meas_valid)
    );

    always #5 clk = ~clk;

    // Crystal model: high for the second half of each period; phase restarts when the period changes
    always @(posedge clk) begin
        #2;
        if (per != last_per) begin
            ph = 0;
            last_per = per;
        end else if (per > 0) begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
        if (per == 0) xtl = 1'b0;
        else          xtl = (ph >= per - per / 2) || (glitch && ph == 2);
    end

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        check("rst_clk_sel", 32'(clk_sel), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        rst = 1'b0;
        tick();

        // good crystal, period 10
        en = 1'b1;
        k = cyc + 1;
        tick_to(k + 1);
        check("good_startup_ready", 32'(ready), 32'd0);
        tick_to(k + 115);
        check("good_mv_early", 32'(meas_valid), 32'd0);
        tick_to(k + 116);
        check("good_mv1", 32'(meas_valid), 32'd1);
        check("good_cnt1", 32'(edge_count), 32'd10);
        check("good_ready_w1", 32'(ready), 32'd0);
        tick_to(k + 117);
        check("good_mv1_pulse", 32'(meas_valid), 32'd0);
        tick_to(k + 217);
        check("good_mv2", 32'(meas_valid), 32'd1);
        check("good_cnt2", 32'(edge_count), 32'd10);
        check("good_ready_w2", 32'(ready), 32'd0);
        tick_to(k + 218);
        check("lock_ready", 32'(ready), 32'd1);
        check("lock_clk_sel", 32'(clk_sel), 32'd1);

        // FORCE_RC pulse of 4 cycles while locked
        force_rc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("force_clk_sel", 32'(clk_sel), 32'd0);
            check("force_ready", 32'(ready), 32'd1);
        end
        force_rc = 1'b0;
        tick();
        check("force_release", 32'(clk_sel), 32'd1);

        // drift to period 5 while locked, then recover
        tick_to(k + 316);
        per = 5;
        tick_to(k + 318);
        check("lk_mv", 32'(meas_valid), 32'd1);
        check("lk_cnt", 32'(edge_count), 32'd10);
        check("lk_ready", 32'(ready), 32'd1);
        tick_to(k + 419);
        check("drift_mv", 32'(meas_valid), 32'd1);
        check("drift_cnt", 32'(edge_count), 32'd20);
        check("drift_ready_slot", 32'(ready), 32'd1);
        per = 10;
        tick_to(k + 420);
        check("drift_ready_drop", 32'(ready), 32'd0);
        check("drift_clk_sel_drop", 32'(clk_sel), 32'd0);
        tick_to(k + 520);
        check("relock_cnt1", 32'(edge_count), 32'd10);
        check("relock_mv1", 32'(meas_valid), 32'd1);
        tick_to(k + 621);
        check("relock_ready_pre", 32'(ready), 32'd0);
        tick_to(k + 622);
        check("relock_ready", 32'(ready), 32'd1);
        check("relock_clk_sel", 32'(clk_sel), 32'd1);

        // reset at locked window cycle 50, then full restart
        tick_to(k + 672);
        rst = 1'b1;
        tick();
        check("mrst_clk_sel", 32'(clk_sel), 32'd0);
        check("mrst_ready", 32'(ready), 32'd0);
        check("mrst_fault", 32'(fault), 32'd0);
        check("mrst_edge_count", 32'(edge_count), 32'd0);
        check("mrst_meas_valid", 32'(meas_valid), 32'd0);
        rst = 1'b0;
        k = cyc + 1;
        tick_to(k + 116);
        check("restart_mv1", 32'(meas_valid), 32'd1);
        check("restart_cnt1", 32'(edge_count), 32'd10);
        tick_to(k + 217);
        check("restart_ready_pre", 32'(ready), 32'd0);
        tick_to(k + 218);
        check("restart_ready", 32'(ready), 32'd1);
        check("restart_clk_sel", 32'(clk_sel), 32'd1);

        // disable: outputs clear, EDGE_COUNT holds
        en = 1'b0;
        tick();
        check("dis_ready", 32'(ready), 32'd0);
        check("dis_clk_sel", 32'(clk_sel), 32'd0);
        check("dis_edge_hold", 32'(edge_count), 32'd10);

        // dead crystal: three failing windows then sticky FAULT
        per = 0;
        repeat (20) tick();
        en = 1'b1;
        k = cyc + 1;
        tick_to(k + 116);
        check("dead_mv1", 32'(meas_valid), 32'd1);
        check("dead_cnt1", 32'(edge_count), 32'd0);
        tick_to(k + 217);
        check("dead_mv2", 32'(meas_valid), 32'd1);
        check("dead_fault2", 32'(fault), 32'd0);
        tick_to(k + 318);
        check("dead_mv3", 32'(meas_valid), 32'd1);
        check("dead_cnt3", 32'(edge_count), 32'd0);
        check("dead_fault3", 32'(fault), 32'd0);
        tick_to(k + 319);
        check("dead_fault", 32'(fault), 32'd1);
        check("dead_clk_sel", 32'(clk_sel), 32'd0);
        tick_to(k + 400);
        check("dead_fault_sticky", 32'(fault), 32'd1);
        en = 1'b0;
        tick();
        check("dead_fault_clear", 32'(fault), 32'd0);

        // 1-cycle glitches between crystal edges
        per = 10;
        glitch = 1'b1;
        repeat (20) tick();
        en = 1'b1;
        k = cyc + 1;
`ifdef OSC_SUP_GLITCH_FILTER_EN
        exp_glitch = 10;
`else
        exp_glitch = 20;
`endif
        tick_to(k + 116);
        check("glitch_mv", 32'(meas_valid), 32'd1);
        check("glitch_cnt", 32'(edge_count), 32'(exp_glitch));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/abfn_uart_1_sb_osc_supervisor.md
# abfn_uart_1_sb_osc_supervisor

Clock-source supervisor for the fabric oscillator block. It runs on the always-available 50 MHz fabric RC oscillator clock and samples the crystal oscillator's fabric output as data. It qualifies the crystal's frequency by counting its edges over fixed measurement windows, then drives the clock-source select: RC until the crystal is proven good, crystal while it stays good, and back to RC on any failed window. Downstream CCC/clock-mux logic and the UART baud generator consume `CLK_SEL` and `READY`.

## Interface
- `STARTUP_CYCLES`, 1024: crystal settle time after enable, in `CLK` cycles.
- `WINDOW_CYCLES`, 4096: measurement window length, in `CLK` cycles.
- `MIN_EDGES`, 78: lowest passing edge count per window, inclusive.
- `MAX_EDGES`, 86: highest passing edge count per window, inclusive.
- `PASS_NEEDED`, 2: consecutive passing windows required to lock.
- `RETRY_MAX`, 3: consecutive failing windows that cause `FAULT`.
- `CLK`  in  1: fabric RC oscillator clock (50 MHz).
- `RESET`  in  1: synchronous, active-high reset. Single clock domain.
- `XTL_CLK_IN`  in  1: crystal oscillator fabric output. Asynchronous; sampled as data; must be below `CLK`/2.
- `ENABLE`  in  1: level. High runs the supervisor; low returns it to IDLE.
- `FORCE_RC`  in  1: level. While high, `CLK_SEL` is held 0 and measurement continues.
- `CLK_SEL`  out  1: 0 selects the RC clock, 1 selects the crystal.
- `READY`  out  1: the crystal is qualified and locked.
- `FAULT`  out  1: sticky crystal failure.
- `EDGE_COUNT`  out  16: edge count from the last completed window.
- `MEAS_VALID`  out  1: one-cycle pulse when `EDGE_COUNT` updates.

## Operation
- **Input path:** 2-flop synchronizer on `XTL_CLK_IN`, then a registered rising-edge detector. Each detected edge increments the window edge counter.
  - The edge counter saturates at 0xFFFF.
- **State machine:** IDLE, STARTUP, MEASURE, EVALUATE, LOCKED, FAULT_ST.
- **IDLE:** moves to STARTUP when `ENABLE`=1. Clears `pass_cnt` and `fail_cnt`.
- **STARTUP:** lasts exactly `STARTUP_CYCLES` cycles, then MEASURE. Edges are ignored.
- **MEASURE:** counts edges for exactly `WINDOW_CYCLES` cycles, then EVALUATE.
- **EVALUATE** (1 cycle):
  - Latches the count into `EDGE_COUNT` and pulses `MEAS_VALID`.
  - A count in `[MIN_EDGES, MAX_EDGES]` is a pass. On pass, `pass_cnt`++ and `fail_cnt`=0. If `pass_cnt` reaches `PASS_NEEDED`, go to LOCKED; otherwise go to MEASURE.
  - On fail, `pass_cnt`=0 and `fail_cnt`++. If `fail_cnt` reaches `RETRY_MAX`, go to FAULT_ST; otherwise go to MEASURE.
- **LOCKED:** measures back-to-back windows of `WINDOW_CYCLES`+1 cycles. The extra cycle is the evaluate slot, where `MEAS_VALID` pulses.
  - A pass stays in LOCKED.
  - A fail goes to MEASURE with `pass_cnt`=0 and `fail_cnt`=1.
- **FAULT_ST:** sticky. Exits only on `RESET` or `ENABLE`=0.
- **Outputs:**
  - `READY` = (state==LOCKED).
  - `CLK_SEL` = (state==LOCKED) & !`FORCE_RC`. Both are registered.
  - `FAULT` = (state==FAULT_ST).
- **Disable:** `ENABLE`=0 in any state goes to IDLE on the next cycle. All outputs clear except `EDGE_COUNT`, which holds.
- **Reset:** `RESET` has priority over `ENABLE` and works from any state, including mid-window. The window is discarded.
  - Every output and state register resets to 0 / IDLE: `CLK_SEL`=0, `READY`=0, `FAULT`=0, `EDGE_COUNT`=0, `MEAS_VALID`=0.

## Timing
- **Edge latency:** a `XTL_CLK_IN` rising edge is counted 3 `CLK` edges later. An edge whose detect cycle falls outside MEASURE or the LOCKED window is not counted.
- **Lock timeline** with `ENABLE` sampled high at edge k:
  - STARTUP: k+1..k+S.
  - Window 1: k+S+1..k+S+W. EVALUATE at k+S+W+1.
  - With `PASS_NEEDED`=2, window 2 ends and evaluates at k+S+2W+2.
  - LOCKED, `READY`=1 and `CLK_SEL`=1 from k+S+2W+3.
- **Unlock:** on a failing LOCKED window, `CLK_SEL` and `READY` drop on the cycle after the evaluate slot.
- **`FORCE_RC`:** a change reaches `CLK_SEL` in 1 cycle.
- **Simultaneous events:** `ENABLE` falling in the EVALUATE cycle gives IDLE next. `EDGE_COUNT` and `MEAS_VALID` still update that cycle.

## Configuration
- `OSC_SUP_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter is inserted between the synchronizer and the edge detector.
  - Single-cycle glitches on `XTL_CLK_IN` are rejected.
  - Edge latency becomes 5 cycles.
- Undefined: no filter; latency is 3 cycles.

## Test plan
Parameters for all scenarios: S=16, W=100, MIN=9, MAX=11, `PASS_NEEDED`=2, `RETRY_MAX`=3.
- **Good crystal:** `XTL_CLK_IN` period 10 `CLK`, `ENABLE` high at k. Required: `MEAS_VALID` at k+117 and k+218 with `EDGE_COUNT`=10±1; `READY`=`CLK_SEL`=1 from k+219.
- **Dead crystal:** `XTL_CLK_IN`=0. Required: three `MEAS_VALID` pulses with `EDGE_COUNT`=0; `FAULT`=1 from the cycle after the third; `CLK_SEL` stays 0.
- **Drift while locked:** after lock, change the period to 5. Required: next `EDGE_COUNT`=20; `CLK_SEL`/`READY` drop the following cycle; re-lock once the period returns to 10.
- **`FORCE_RC` while locked:** pulse high for 4 cycles. Required: `CLK_SEL`=0 for 4 cycles (1-cycle delay); `READY` stays 1.
- **Reset mid-window:** `RESET` 1 cycle at window cycle 50. Required: all outputs 0 next cycle, state IDLE; restart gives the full timeline again.
- **Filter build:** with `OSC_SUP_GLITCH_FILTER_EN`, add 1-cycle glitches between edges. Required: `EDGE_COUNT` still 10±1. Without the macro, the count rises.
